// File: rtl/pcie_tx_pkg.sv
// Shared TX lane constants: ordered-set symbols, fixed words and scheduler state encoding.
// A saturating counter helper is also provided for the optional TX_SKP_COUNT_EN statistics.
package pcie_tx_pkg;

  localparam logic [7:0]  COM_SYM     = 8'hBC;
  localparam logic [7:0]  SKP_SYM     = 8'h1C;
  localparam logic [31:0] SKP_OS_WORD = {SKP_SYM, SKP_SYM, SKP_SYM, COM_SYM};
  localparam logic [31:0] IDLE_WORD   = 32'h0000_0000;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SKP  = 2'd1;
  localparam logic [1:0] ST_OS   = 2'd2;
  localparam logic [1:0] ST_DATA = 2'd3;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  datak;
    logic        os_word;
  } tx_word_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] value);
    if (value == 16'hFFFF) begin
      return value;
    end else begin
      return value + 16'h0001;
    end
  endfunction

endpackage

// File: rtl/tx_lane_scheduler_skp_timer.sv
// SKP interval timer: raises skp_pending every SKP_INTERVAL cycles while skp_en is high,
// and records a sticky skp_miss when an interval expires with a request still outstanding.
module tx_skp_timer
  import pcie_tx_pkg::*;
#(
  parameter int SKP_INTERVAL = 295,
  parameter int CNT_W        = 12
) (
  input  logic clk,
  input  logic reset,
  input  logic skp_en,
  input  logic skp_sent,
  output logic skp_pending,
  output logic skp_miss
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SKP_INTERVAL - 1);

  logic [CNT_W-1:0] cnt_r;
  logic             pending_r;
  logic             miss_r;
  logic             expire_s;

  assign expire_s = skp_en & (cnt_r == CNT_LAST);

  // Interval counter, pending request and sticky miss flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_r     <= '0;
      pending_r <= 1'b0;
      miss_r    <= 1'b0;
    end else if (!skp_en) begin
      cnt_r     <= '0;
      pending_r <= 1'b0;
    end else begin
      cnt_r <= expire_s ? '0 : cnt_r + CNT_W'(1);
      // A new expiry always re-arms, even in the cycle the previous SKP goes out.
      if (expire_s) begin
        pending_r <= 1'b1;
      end else if (skp_sent) begin
        pending_r <= 1'b0;
      end
      if (expire_s && pending_r && !skp_sent) begin
        miss_r <= 1'b1;
      end
    end
  end

  assign skp_pending = pending_r;
  assign skp_miss    = miss_r;

endmodule

// File: rtl/tx_lane_scheduler.sv
// Per-lane TX word scheduler arbitrating SKP, LTSSM ordered sets and link-layer data into one word stream.
// Optional build macro TX_SKP_COUNT_EN enables the saturating skp_count statistic.
module tx_lane_scheduler
  import pcie_tx_pkg::*;
#(
  parameter int SKP_INTERVAL = 295,
  parameter int CNT_W        = 12
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        skp_en,
  input  logic        scr_disable,
  input  logic        os_valid,
  input  logic [31:0] os_data,
  input  logic [3:0]  os_datak,
  input  logic        os_last,
  output logic        os_ready,
  input  logic        dl_valid,
  input  logic [31:0] dl_data,
  input  logic [3:0]  dl_datak,
  input  logic        dl_sop,
  input  logic        dl_eop,
  output logic        dl_ready,
  output logic [31:0] tx_data,
  output logic [3:0]  tx_datak,
  output logic        turn_off,
  output logic        skp_miss,
  output logic        os_err,
  output logic [15:0] skp_count
);

  logic [1:0]  state_r;
  logic [1:0]  state_nxt_s;
  tx_word_t    word_s;
  logic        skp_pending_s;
  logic        skp_sent_s;
  logic        os_err_set_s;
  logic [31:0] tx_data_r;
  logic [3:0]  tx_datak_r;
  logic        turn_off_r;
  logic        os_err_r;

  tx_skp_timer #(
    .SKP_INTERVAL (SKP_INTERVAL),
    .CNT_W        (CNT_W)
  ) u_skp_timer (
    .clk         (clk),
    .reset       (reset),
    .skp_en      (skp_en),
    .skp_sent    (skp_sent_s),
    .skp_pending (skp_pending_s),
    .skp_miss    (skp_miss)
  );

  assign os_ready = (state_r == ST_OS);
  assign dl_ready = (state_r == ST_DATA);

  // Word selection and next-state decode; every handover goes back through IDLE
  always_comb begin
    state_nxt_s  = state_r;
    word_s       = '{data: IDLE_WORD, datak: 4'h0, os_word: 1'b0};
    skp_sent_s   = 1'b0;
    os_err_set_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (skp_pending_s) begin
          state_nxt_s = ST_SKP;
        end else if (os_valid) begin
          state_nxt_s = ST_OS;
        end else if (dl_valid && dl_sop) begin
          state_nxt_s = ST_DATA;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_SKP: begin
        word_s      = '{data: SKP_OS_WORD, datak: 4'hF, os_word: 1'b0};
        skp_sent_s  = 1'b1;
        state_nxt_s = ST_IDLE;
      end
      ST_OS: begin
        if (os_valid) begin
          word_s      = '{data: os_data, datak: os_datak, os_word: 1'b1};
          state_nxt_s = os_last ? ST_IDLE : ST_OS;
        end else begin
          os_err_set_s = 1'b1;
          state_nxt_s  = ST_OS;
        end
      end
      ST_DATA: begin
        // SKP requests wait here until the packet closes.
        if (dl_valid) begin
          word_s      = '{data: dl_data, datak: dl_datak, os_word: 1'b0};
          state_nxt_s = dl_eop ? ST_IDLE : ST_DATA;
        end else begin
          state_nxt_s = ST_DATA;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State, registered word outputs and the sticky ordered-set error
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= ST_IDLE;
      tx_data_r  <= 32'h0;
      tx_datak_r <= 4'h0;
      turn_off_r <= 1'b0;
      os_err_r   <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      tx_data_r  <= word_s.data;
      tx_datak_r <= word_s.datak;
      turn_off_r <= scr_disable | word_s.os_word;
      os_err_r   <= os_err_r | os_err_set_s;
    end
  end

  assign tx_data  = tx_data_r;
  assign tx_datak = tx_datak_r;
  assign turn_off = turn_off_r;
  assign os_err   = os_err_r;

`ifdef TX_SKP_COUNT_EN
  logic [15:0] skp_count_r;

  // Saturating count of SKP ordered sets put on the lane
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      skp_count_r <= 16'h0;
    end else if (skp_sent_s) begin
      skp_count_r <= sat_inc16(skp_count_r);
    end
  end

  assign skp_count = skp_count_r;
`else
  assign skp_count = 16'h0;
`endif

endmodule

// File: tb/tb_tx_lane_scheduler.sv
// Self-checking bench for tx_lane_scheduler (SKP_INTERVAL=8): vector table plus SKP/OS/reset sequences.
module tb_tx_lane_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        skp_en, scr_disable;
  logic        os_valid, os_last, os_ready;
  logic [31:0] os_data;
  logic [3:0]  os_datak;
  logic        dl_valid, dl_sop, dl_eop, dl_ready;
  logic [31:0] dl_data;
  logic [3:0]  dl_datak;
  logic [31:0] tx_data;
  logic [3:0]  tx_datak;
  logic        turn_off, skp_miss, os_err;
  logic [15:0] skp_count;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic        pkt_open;
  int          skp_in_pkt;
  logic [31:0] pkt_first, pkt_last;

  localparam logic [35:0] SKP_K_WORD = {4'hF, 32'h1C1C1CBC};

  tx_lane_scheduler #(.SKP_INTERVAL(8), .CNT_W(4)) dut (
    .clk(clk), .reset(rst), .skp_en(skp_en), .scr_disable(scr_disable),
    .os_valid(os_valid), .os_data(os_data), .os_datak(os_datak), .os_last(os_last), .os_ready(os_ready),
    .dl_valid(dl_valid), .dl_data(dl_data), .dl_datak(dl_datak), .dl_sop(dl_sop), .dl_eop(dl_eop),
    .dl_ready(dl_ready), .tx_data(tx_data), .tx_datak(tx_datak), .turn_off(turn_off),
    .skp_miss(skp_miss), .os_err(os_err), .skp_count(skp_count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Advance one clock; also watches the output for SKP words inside an open packet
  task automatic tick();
    @(posedge clk);
    #1;
    if ({tx_datak, tx_data} == SKP_K_WORD && pkt_open) skp_in_pkt++;
    if (tx_data == pkt_first) pkt_open = 1'b1;
    if (tx_data == pkt_last) pkt_open = 1'b0;
  endtask

  task automatic clear_inputs();
    scr_disable = 1'b0;
    os_valid = 1'b0; os_data = 32'h0; os_datak = 4'h0; os_last = 1'b0;
    dl_valid = 1'b0; dl_data = 32'h0; dl_datak = 4'h0; dl_sop = 1'b0; dl_eop = 1'b0;
  endtask

  task automatic do_reset(input logic en);
    rst = 1'b1;
    skp_en = 1'b0;
    clear_inputs();
    pkt_open = 1'b0; skp_in_pkt = 0; pkt_first = 32'hFFFF_FFFF; pkt_last = 32'hFFFF_FFFF;
    tick();
    tick();
    skp_en = en;
    rst = 1'b0;
  endtask

  task automatic send_dl(input int n);
    logic        acc;
    int          guard;
    logic [31:0] beat;
    pkt_first = 32'hD000_0000;
    pkt_last  = 32'hD000_0000 + 32'(n - 1);
    for (int b = 0; b < n; b++) begin
      beat = 32'hD000_0000 + 32'(b);
      dl_valid = 1'b1; dl_data = beat; dl_datak = 4'h0;
      dl_sop = (b == 0); dl_eop = (b == n - 1);
      acc = 1'b0; guard = 0;
      while (!acc && guard < 50) begin
        acc = dl_ready;
        tick();
        guard++;
      end
      if (!acc) chk("dl_accept_timeout", 64'd0, 64'd1);
      else chk("dl_beat", {tx_datak, tx_data}, {4'h0, beat});
    end
    clear_inputs();
  endtask

  typedef struct {
    logic        osv; logic [31:0] osd; logic [3:0] osk; logic osl;
    logic        dlv; logic [31:0] dld; logic dls; logic dle; logic sd;
    logic [31:0] e_data; logic [3:0] e_datak; logic e_toff; logic e_osr; logic e_dlr;
  } vec_t;

  vec_t vt[15];

  initial begin
    // Table: OS and DL requested together, TS1 first, then the packet, drop of sop-less data
    vt[0]  = '{1'b1, 32'h02F7F7BC, 4'h7, 1'b0, 1'b1, 32'h11223344, 1'b1, 1'b0, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0};
    vt[1]  = '{1'b1, 32'h02F7F7BC, 4'h7, 1'b0, 1'b1, 32'h11223344, 1'b1, 1'b0, 1'b0, 32'h02F7F7BC, 4'h7, 1'b1, 1'b1, 1'b0};
    vt[2]  = '{1'b1, 32'h4A4A0402, 4'h0, 1'b0, 1'b1, 32'h11223344, 1'b1, 1'b0, 1'b0, 32'h4A4A0402, 4'h0, 1'b1, 1'b1, 1'b0};
    vt[3]  = '{1'b1, 32'h4A4A4A4A, 4'h0, 1'b0, 1'b1, 32'h11223344, 1'b1, 1'b0, 1'b0, 32'h4A4A4A4A, 4'h0, 1'b1, 1'b1, 1'b0};
    vt[4]  = '{1'b1, 32'h4B4A4A4A, 4'h0, 1'b1, 1'b1, 32'h11223344, 1'b1, 1'b0, 1'b0, 32'h4B4A4A4A, 4'h0, 1'b1, 1'b1, 1'b0};
    vt[5]  = '{1'b0, 32'h0,        4'h0, 1'b0, 1'b1, 32'h11223344, 1'b1, 1'b0, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0};
    vt[6]  = '{1'b0, 32'h0,        4'h0, 1'b0, 1'b1, 32'h11223344, 1'b1, 1'b0, 1'b0, 32'h11223344, 4'h0, 1'b0, 1'b0, 1'b1};
    vt[7]  = '{1'b0, 32'h0,        4'h0, 1'b0, 1'b1, 32'h55667788, 1'b0, 1'b0, 1'b0, 32'h55667788, 4'h0, 1'b0, 1'b0, 1'b1};
    vt[8]  = '{1'b0, 32'h0,        4'h0, 1'b0, 1'b1, 32'h99AABBCC, 1'b0, 1'b1, 1'b0, 32'h99AABBCC, 4'h0, 1'b0, 1'b0, 1'b1};
    vt[9]  = '{1'b0, 32'h0,        4'h0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 32'h0, 4'h0, 1'b1, 1'b0, 1'b0};
    vt[10] = '{1'b0, 32'h0,        4'h0, 1'b0, 1'b1, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0};
    vt[11] = '{1'b0, 32'h0,        4'h0, 1'b0, 1'b1, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0};
    vt[12] = '{1'b1, 32'h02F7F7BC, 4'h7, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0};
    vt[13] = '{1'b1, 32'h02F7F7BC, 4'h7, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 32'h02F7F7BC, 4'h7, 1'b1, 1'b1, 1'b0};
    vt[14] = '{1'b0, 32'h0,        4'h0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0};

    // Reset state with busy inputs
    pkt_open = 1'b0; skp_in_pkt = 0; pkt_first = 32'hFFFF_FFFF; pkt_last = 32'hFFFF_FFFF;
    rst = 1'b1; skp_en = 1'b1; clear_inputs(); os_valid = 1'b1; dl_valid = 1'b1; dl_sop = 1'b1;
    tick();
    chk("reset_tx", {turn_off, tx_datak, tx_data}, 64'h0);
    chk("reset_readys", {os_ready, dl_ready}, 64'h0);
    chk("reset_sticky", {skp_miss, os_err}, 64'h0);
    chk("reset_skp_count", skp_count, 64'h0);

    // Table-driven arbitration
    do_reset(1'b0);
    for (int i = 0; i < 15; i++) begin
      os_valid = vt[i].osv; os_data = vt[i].osd; os_datak = vt[i].osk; os_last = vt[i].osl;
      dl_valid = vt[i].dlv; dl_data = vt[i].dld; dl_datak = 4'h0; dl_sop = vt[i].dls; dl_eop = vt[i].dle;
      scr_disable = vt[i].sd;
      #1;
      chk($sformatf("vec%0d_readys", i), {os_ready, dl_ready}, {vt[i].e_osr, vt[i].e_dlr});
      tick();
      chk($sformatf("vec%0d_word", i), {turn_off, tx_datak, tx_data}, {vt[i].e_toff, vt[i].e_datak, vt[i].e_data});
    end
    chk("table_os_err", os_err, 64'h0);

    // Periodic SKP with an idle lane: first SKP after the 10th edge, then every 8
    do_reset(1'b1);
    for (int n = 1; n <= 40; n++) begin
      tick();
      if (n >= 10 && ((n - 10) % 8) == 0)
        chk($sformatf("skp_periodic_c%0d", n), {turn_off, tx_datak, tx_data}, {1'b0, SKP_K_WORD});
      else
        chk($sformatf("skp_periodic_c%0d", n), {turn_off, tx_datak, tx_data}, 64'h0);
    end
    chk("skp_periodic_miss", skp_miss, 64'h0);
`ifdef TX_SKP_COUNT_EN
    chk("skp_count", skp_count, 64'd4);
`else
    chk("skp_count", skp_count, 64'd0);
`endif

    // 12-word packet: one expiry inside, SKP held until after the eop idle word
    do_reset(1'b1);
    send_dl(12);
    tick();
    chk("pkt12_eop_idle", {tx_datak, tx_data}, 64'h0);
    tick();
    chk("pkt12_skp", {tx_datak, tx_data}, SKP_K_WORD);
    chk("pkt12_skp_in_pkt", skp_in_pkt, 64'd0);
    chk("pkt12_miss", skp_miss, 64'h0);

    // 20-word packet: two expiries inside -> miss, a single SKP afterwards
    do_reset(1'b1);
    send_dl(20);
    tick();
    chk("pkt20_eop_idle", {tx_datak, tx_data}, 64'h0);
    tick();
    chk("pkt20_skp", {tx_datak, tx_data}, SKP_K_WORD);
    tick();
    chk("pkt20_after1", {tx_datak, tx_data}, 64'h0);
    tick();
    chk("pkt20_after2", {tx_datak, tx_data}, 64'h0);
    chk("pkt20_skp_in_pkt", skp_in_pkt, 64'd0);
    chk("pkt20_miss", skp_miss, 64'h1);

    // Ordered set with a one-cycle gap between words 2 and 3
    do_reset(1'b0);
    os_valid = 1'b1; os_data = 32'h02F7F7BC; os_datak = 4'h7;
    tick();
    tick();
    chk("osgap_w0", {turn_off, tx_datak, tx_data}, {1'b1, 4'h7, 32'h02F7F7BC});
    os_data = 32'h4A4A0402; os_datak = 4'h0;
    tick();
    chk("osgap_w1", {turn_off, tx_datak, tx_data}, {1'b1, 4'h0, 32'h4A4A0402});
    chk("osgap_err_before", os_err, 64'h0);
    os_valid = 1'b0;
    tick();
    chk("osgap_idle", {turn_off, tx_datak, tx_data}, 64'h0);
    chk("osgap_err_after", os_err, 64'h1);
    os_valid = 1'b1; os_data = 32'h4A4A4A4A;
    tick();
    chk("osgap_w2", {turn_off, tx_datak, tx_data}, {1'b1, 4'h0, 32'h4A4A4A4A});
    os_data = 32'h4B4A4A4A; os_last = 1'b1;
    tick();
    chk("osgap_w3", {turn_off, tx_datak, tx_data}, {1'b1, 4'h0, 32'h4B4A4A4A});
    clear_inputs();
    #1;
    chk("osgap_back_idle", os_ready, 64'h0);

    // Asynchronous reset in the middle of a packet
    do_reset(1'b0);
    scr_disable = 1'b1;
    dl_valid = 1'b1; dl_data = 32'h55AA55AA; dl_sop = 1'b1;
    tick();
    tick();
    dl_sop = 1'b0;
    tick();
    chk("midrst_pre", {turn_off, dl_ready, tx_data}, {1'b1, 1'b1, 32'h55AA55AA});
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_tx_clear", {turn_off, tx_datak, tx_data}, 64'h0);
    chk("midrst_ready_clear", {os_ready, dl_ready}, 64'h0);
    scr_disable = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    chk("midrst_idle_after", {dl_ready, tx_data}, 64'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
